// File: rtl/qam16_pkg.sv
// Shared constants and types for the 16-QAM coherent demodulator.
package qam16_pkg;

  localparam int unsigned CAR_W = 10;
  localparam int unsigned BR_W  = 13;

  localparam logic [1:0] LVL_M3 = 2'b00;
  localparam logic [1:0] LVL_M1 = 2'b01;
  localparam logic [1:0] LVL_P1 = 2'b11;
  localparam logic [1:0] LVL_P3 = 2'b10;

  typedef enum logic {
    WAIT_ALIGN = 1'b0,
    INTEGRATE  = 1'b1
  } state_t;

endpackage

// File: rtl/qam16_slicer.sv
// Four-level decision slicer; ties resolve toward the higher level.
module qam16_slicer
  import qam16_pkg::*;
#(
  parameter int unsigned ACC_W  = 28,
  parameter int unsigned THRESH = 4177936
) (
  input  logic signed [ACC_W-1:0] tot_i,
  output logic        [1:0]       code_o
);

  localparam logic signed [ACC_W-1:0] TH_P = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] TH_N = -ACC_W'(THRESH);

  always_comb begin
    code_o = LVL_M3;
    if (tot_i >= TH_P)        code_o = LVL_P3;
    else if (!tot_i[ACC_W-1]) code_o = LVL_P1;
    else if (tot_i >= TH_N)   code_o = LVL_M1;
  end

endmodule

// File: rtl/qam16_coherent_demod.sv
// Coherent mix, integrate-and-dump and slice of the loop-back 16-QAM composite signal.
module qam16_coherent_demod
  import qam16_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_SYM = 16,
  parameter int unsigned ACC_W           = 28,
  parameter int unsigned THRESH          = 4177936
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_en,
  input  logic                    sym_align,
  input  logic signed [BR_W-1:0]  I_mod,
  input  logic signed [BR_W-1:0]  Q_mod,
  input  logic signed [CAR_W-1:0] SinWave,
  input  logic signed [CAR_W-1:0] CosWave,
  output logic [1:0]              SigI_hat,
  output logic [1:0]              SigQ_hat,
  output logic                    sym_valid,
  output logic                    locked,
  output logic [15:0]             sym_count
);

  localparam int unsigned CNT_W = $clog2(SAMPLES_PER_SYM);

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic s1_vld_q, s1_vld_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic signed [BR_W:0]    r_q, r_d;
  logic signed [CAR_W-1:0] sin_q, sin_d, cos_q, cos_d;

  logic s2_vld_q, s2_vld_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
  logic signed [23:0] pI_q, pI_d, pQ_q, pQ_d;

  logic signed [ACC_W-1:0] accI_q, accI_d, accQ_q, accQ_d;
  logic signed [ACC_W-1:0] baseI, baseQ, totI, totQ;

  logic [1:0]  sigi_q, sigi_d, sigq_q, sigq_d, codeI, codeQ;
  logic        valid_q, valid_d, locked_q, locked_d;
  logic [15:0] count_q, count_d;
  logic        accept, realign;

  qam16_slicer #(.ACC_W(ACC_W), .THRESH(THRESH)) u_slice_i (.tot_i(totI), .code_o(codeI));
  qam16_slicer #(.ACC_W(ACC_W), .THRESH(THRESH)) u_slice_q (.tot_i(totQ), .code_o(codeQ));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    s1_vld_d   = 1'b0;
    s1_first_d = 1'b0;
    s1_last_d  = 1'b0;
    accI_d     = accI_q;
    accQ_d     = accQ_q;
    sigi_d     = sigi_q;
    sigq_d     = sigq_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
    count_d    = count_q;

    accept  = sample_en && (state_q == INTEGRATE || sym_align);
    realign = sample_en && sym_align && (state_q == INTEGRATE);

    if (sample_en && sym_align) state_d = INTEGRATE;

    if (accept) begin
      s1_vld_d = 1'b1;
      if (sym_align) begin
        s1_first_d = 1'b1;
        cnt_d      = CNT_W'(1);
      end else begin
        s1_first_d = (cnt_q == '0);
        s1_last_d  = (cnt_q == CNT_W'(SAMPLES_PER_SYM - 1));
        cnt_d      = cnt_q + 1'b1;
      end
    end

    r_d   = (BR_W + 1)'(I_mod) + (BR_W + 1)'(Q_mod);
    sin_d = SinWave;
    cos_d = CosWave;

    // Re-align drops the partial symbol still in stage 1; a completed symbol's
    // last sample is allowed to finish its dump.
    s2_vld_d   = s1_vld_q && (!realign || s1_last_q);
    s2_first_d = s1_first_q;
    s2_last_d  = s1_last_q;
    pI_d       = 24'(r_q) * 24'(sin_q);
    pQ_d       = 24'(r_q) * 24'(cos_q);

    baseI = s2_first_q ? '0 : accI_q;
    baseQ = s2_first_q ? '0 : accQ_q;
    totI  = baseI + ACC_W'(pI_q);
    totQ  = baseQ + ACC_W'(pQ_q);

    if (s2_vld_q) begin
      if (s2_last_q) begin
        accI_d   = '0;
        accQ_d   = '0;
        sigi_d   = codeI;
        sigq_d   = codeQ;
        valid_d  = 1'b1;
        locked_d = 1'b1;
        count_d  = count_q + 16'd1;
      end else begin
        accI_d = totI;
        accQ_d = totQ;
      end
    end

    if (realign) locked_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_ALIGN;
      cnt_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      r_q        <= '0;
      sin_q      <= '0;
      cos_q      <= '0;
      s2_vld_q   <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      pI_q       <= '0;
      pQ_q       <= '0;
      accI_q     <= '0;
      accQ_q     <= '0;
      sigi_q     <= '0;
      sigq_q     <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_vld_q   <= s1_vld_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      r_q        <= r_d;
      sin_q      <= sin_d;
      cos_q      <= cos_d;
      s2_vld_q   <= s2_vld_d;
      s2_first_q <= s2_first_d;
      s2_last_q  <= s2_last_d;
      pI_q       <= pI_d;
      pQ_q       <= pQ_d;
      accI_q     <= accI_d;
      accQ_q     <= accQ_d;
      sigi_q     <= sigi_d;
      sigq_q     <= sigq_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      count_q    <= count_d;
    end
  end

  assign SigI_hat  = sigi_q;
  assign SigQ_hat  = sigq_q;
  assign sym_valid = valid_q;
  assign locked    = locked_q;
  assign sym_count = count_q;

endmodule

// File: tb/tb_qam16_coherent_demod.sv
// Directed bench: default-threshold instance plus a THRESH=16 instance for tie cases.
module tb_qam16_coherent_demod;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sample_en = 1'b0;
  logic              sym_align = 1'b0;
  logic signed [12:0] I_mod = '0;
  logic signed [12:0] Q_mod = '0;
  logic signed [9:0]  SinWave = '0;
  logic signed [9:0]  CosWave = '0;

  logic [1:0]  SigI_hat, SigQ_hat, SigI_t, SigQ_t;
  logic        sym_valid, locked, sym_valid_t, locked_t;
  logic [15:0] sym_count, sym_count_t;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  qam16_coherent_demod #(.SAMPLES_PER_SYM(16), .ACC_W(28), .THRESH(4177936)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .sym_align(sym_align),
    .I_mod(I_mod), .Q_mod(Q_mod), .SinWave(SinWave), .CosWave(CosWave),
    .SigI_hat(SigI_hat), .SigQ_hat(SigQ_hat), .sym_valid(sym_valid),
    .locked(locked), .sym_count(sym_count)
  );

  qam16_coherent_demod #(.SAMPLES_PER_SYM(16), .ACC_W(28), .THRESH(16)) dut_t (
    .clk(clk), .rst(rst), .sample_en(sample_en), .sym_align(sym_align),
    .I_mod(I_mod), .Q_mod(Q_mod), .SinWave(SinWave), .CosWave(CosWave),
    .SigI_hat(SigI_t), .SigQ_hat(SigQ_t), .sym_valid(sym_valid_t),
    .locked(locked_t), .sym_count(sym_count_t)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i_v, input int q_v, input int s_v, input int c_v);
    I_mod   = 13'(i_v);
    Q_mod   = 13'(q_v);
    SinWave = 10'(s_v);
    CosWave = 10'(c_v);
  endtask

  // One 16-sample symbol; sym_valid must appear exactly 3 cycles after the last strobe.
  task automatic run_sym(input string tag, input int i_v, input int q_v, input int s_v,
                         input int c_v, input bit align, input int gap, input bit chk_unlock,
                         input logic [1:0] expI, input logic [1:0] expQ,
                         input logic [1:0] expIt, input logic [1:0] expQt);
    bit early = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(i_v, q_v, s_v, c_v);
      sample_en = 1'b1;
      sym_align = align && (i == 0);
      tick();
      sample_en = 1'b0;
      sym_align = 1'b0;
      if (sym_valid) early = 1'b1;
      if (chk_unlock && i == 0) check({tag, "_unlock"}, 32'(locked), 32'd0);
      if (i != 15) repeat (gap) begin
        tick();
        if (sym_valid) early = 1'b1;
      end
    end
    tick();
    check({tag, "_no_early_valid"}, 32'(early | sym_valid), 32'd0);
    tick();
    exp_cnt++;
    check({tag, "_valid"},  32'(sym_valid), 32'd1);
    check({tag, "_I"},      32'(SigI_hat),  32'(expI));
    check({tag, "_Q"},      32'(SigQ_hat),  32'(expQ));
    check({tag, "_locked"}, 32'(locked),    32'd1);
    check({tag, "_count"},  32'(sym_count), 32'(exp_cnt));
    check({tag, "_tI"},     32'(SigI_t),    32'(expIt));
    check({tag, "_tQ"},     32'(SigQ_t),    32'(expQt));
  endtask

  initial begin
    bit seen;
    repeat (2) tick();
    check("rst_I", 32'(SigI_hat), 32'd0);
    check("rst_Q", 32'(SigQ_hat), 32'd0);
    check("rst_valid", 32'(sym_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_count", 32'(sym_count), 32'd0);
    rst = 1'b0;
    tick();

    run_sym("dc_p1",  768,   0, 256,    0, 1'b1, 0, 1'b0, 2'b11, 2'b11, 2'b10, 2'b11);
    run_sym("dc_m1", -768,   0, 256,    0, 1'b1, 0, 1'b0, 2'b01, 2'b11, 2'b00, 2'b11);
    run_sym("dc_m3", -1533,  0, 511,    0, 1'b1, 0, 1'b0, 2'b00, 2'b11, 2'b00, 2'b11);
    run_sym("q_m1",     0, 768,   0, -256, 1'b1, 0, 1'b0, 2'b11, 2'b01, 2'b11, 2'b00);
    run_sym("gapped", 768,   0, 256,    0, 1'b1, 2, 1'b0, 2'b11, 2'b11, 2'b10, 2'b11);

    // Partial symbol continuing the running counter, then re-align at its 8th sample.
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(-1533, 0, 511, 0);
      sample_en = 1'b1;
      tick();
      sample_en = 1'b0;
      if (sym_valid) seen = 1'b1;
    end
    check("pre_realign_locked", 32'(locked), 32'd1);
    run_sym("realign", 768, 0, 256, 0, 1'b1, 0, 1'b1, 2'b11, 2'b11, 2'b10, 2'b11);
    check("partial_no_valid", 32'(seen), 32'd0);

    // Asynchronous reset in the middle of a symbol.
    for (int i = 0; i < 8; i++) begin
      drive(768, 0, 256, 0);
      sample_en = 1'b1;
      tick();
      sample_en = 1'b0;
    end
    rst = 1'b1;
    #2;
    check("midrst_I", 32'(SigI_hat), 32'd0);
    check("midrst_Q", 32'(SigQ_hat), 32'd0);
    check("midrst_locked", 32'(locked), 32'd0);
    check("midrst_count", 32'(sym_count), 32'd0);
    tick();
    rst = 1'b0;
    exp_cnt = 0;

    // Without alignment every sample must be ignored.
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(768, 0, 256, 0);
      sample_en = (i < 16);
      tick();
      if (sym_valid || locked) seen = 1'b1;
    end
    sample_en = 1'b0;
    check("no_align_ignored", 32'(seen), 32'd0);

    run_sym("tie_p",  1, 0, 1, 0, 1'b1, 0, 1'b0, 2'b11, 2'b11, 2'b10, 2'b11);
    run_sym("tie_m", -1, 0, 1, 0, 1'b1, 0, 1'b0, 2'b01, 2'b11, 2'b01, 2'b11);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
